// File: rtl/meter_controller.sv
// ---------------------------------------------------------------------------
// meter_controller
//   Parking-meter style countdown timer. Button pulses add time, switch rising
//   edges preset the time, and a prescaled 1 s tick counts the time down to
//   zero. The display blank output flashes at 1 Hz when the time is zero and
//   at 0.5 Hz when the time is low. It stays solid at 200 s and above.
//
//   Optional feature: define METER_BCD_EN to build a sequential binary-to-BCD
//   converter that drives bcd/bcd_valid. Without it, bcd and bcd_valid are
//   tied to zero.
//
// Parameters
//   TICK_DIV  clk cycles per second (even, >= 4)
//   MAX_TIME  saturation limit in seconds
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   add_u      in   single-cycle pulse, +50 s
//   add_l      in   single-cycle pulse, +150 s
//   add_r      in   single-cycle pulse, +200 s
//   add_d      in   single-cycle pulse, +500 s
//   sw0        in   level, rising edge presets 10 s
//   sw1        in   level, rising edge presets 205 s
//   time_out   out  remaining seconds, binary [13:0]
//   blank      out  1 = display dark (flash off phase)
//   bcd        out  four BCD digits of time_out, thousands in [15:12]
//   bcd_valid  out  bcd matches the current time_out
// ---------------------------------------------------------------------------
module meter_controller #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned MAX_TIME = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add_u,
  input  logic        add_l,
  input  logic        add_r,
  input  logic        add_d,
  input  logic        sw0,
  input  logic        sw1,
  output logic [13:0] time_out,
  output logic        blank,
  output logic [15:0] bcd,
  output logic        bcd_valid
);

  localparam int unsigned HALF_DIV = TICK_DIV / 2;
  localparam int unsigned CNT_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned TIME_W   = 14;
  localparam int unsigned SUM_W    = TIME_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HALF_DIV - 1);
  localparam logic [TIME_W-1:0] ADD_U_SEC = TIME_W'(50);
  localparam logic [TIME_W-1:0] ADD_L_SEC = TIME_W'(150);
  localparam logic [TIME_W-1:0] ADD_R_SEC = TIME_W'(200);
  localparam logic [TIME_W-1:0] ADD_D_SEC = TIME_W'(500);
  localparam logic [TIME_W-1:0] SW0_SEC   = TIME_W'(10);
  localparam logic [TIME_W-1:0] SW1_SEC   = TIME_W'(205);
  localparam logic [TIME_W-1:0] SOLID_MIN = TIME_W'(200);
  localparam logic [TIME_W-1:0] MAX_T     = TIME_W'(MAX_TIME);
  localparam logic [SUM_W-1:0]  MAX_SUM   = SUM_W'(MAX_TIME);

  typedef enum logic [1:0] {
    ST_ZERO  = 2'd0,
    ST_LOW   = 2'd1,
    ST_SOLID = 2'd2
  } state_t;

  logic              run;
  logic [CNT_W-1:0]  cnt;
  logic              phase;
  logic              half_tick;
  logic              sec_tick;
  logic              sw0_q;
  logic              sw1_q;
  logic              sw0_rise;
  logic              sw1_rise;
  logic              add_hit;
  logic              preset_hit;
  logic [TIME_W-1:0] add_amt;
  logic [TIME_W-1:0] preset_val;
  logic [SUM_W-1:0]  sum;
  logic [TIME_W-1:0] time_next;
  state_t            state_q;
  state_t            state_next;
  logic              blank_next;

  // Reset-release flag. It rises on the 1st edge after rst_n deasserts, so the
  // logic starts on the 2nd edge. Events are ignored until then, and the switch
  // edge detectors sample their current level first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Free-running half-second prescaler. phase selects every second half tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (run) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (half_tick) begin
        phase <= ~phase;
      end
    end
  end

  assign half_tick = run && (cnt == CNT_LAST);
  assign sec_tick  = half_tick && phase;

  // Switch edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw0_q <= 1'b0;
      sw1_q <= 1'b0;
    end else begin
      sw0_q <= sw0;
      sw1_q <= sw1;
    end
  end

  assign sw0_rise = sw0 && !sw0_q;
  assign sw1_rise = sw1 && !sw1_q;

  // Accept at most one event per cycle. The first match in priority order wins.
  always_comb begin
    add_hit    = 1'b0;
    preset_hit = 1'b0;
    add_amt    = '0;
    preset_val = '0;
    if (run) begin
      if (add_u) begin
        add_hit = 1'b1;
        add_amt = ADD_U_SEC;
      end else if (add_l) begin
        add_hit = 1'b1;
        add_amt = ADD_L_SEC;
      end else if (add_r) begin
        add_hit = 1'b1;
        add_amt = ADD_R_SEC;
      end else if (add_d) begin
        add_hit = 1'b1;
        add_amt = ADD_D_SEC;
      end else if (sw0_rise) begin
        preset_hit = 1'b1;
        preset_val = SW0_SEC;
      end else if (sw1_rise) begin
        preset_hit = 1'b1;
        preset_val = SW1_SEC;
      end
    end
  end

  // Next time value. An accepted event replaces that second's decrement.
  always_comb begin
    sum       = {1'b0, time_out} + {1'b0, add_amt};
    time_next = time_out;
    if (add_hit) begin
      time_next = (sum > MAX_SUM) ? MAX_T : sum[TIME_W-1:0];
    end else if (preset_hit) begin
      time_next = preset_val;
    end else if (sec_tick && (time_out != '0)) begin
      time_next = time_out - TIME_W'(1);
    end
  end

  // State, blank and time registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ZERO;
      blank    <= 1'b0;
      time_out <= '0;
    end else begin
      state_q  <= state_next;
      blank    <= blank_next;
      time_out <= time_next;
    end
  end

  // The state follows the next time value. blank restarts lit on every change.
  always_comb begin
    state_next = ST_SOLID;
    blank_next = 1'b0;
    if (time_next == '0) begin
      state_next = ST_ZERO;
    end else if (time_next < SOLID_MIN) begin
      state_next = ST_LOW;
    end
    if (state_next == state_q) begin
      case (state_q)
        ST_ZERO:  blank_next = half_tick ? ~blank : blank;
        ST_LOW:   blank_next = sec_tick ? ~blank : blank;
        default:  blank_next = 1'b0;
      endcase
    end
  end

`ifdef METER_BCD_EN
  localparam int unsigned DIGITS_W = 16;
  localparam int unsigned DD_W     = DIGITS_W + TIME_W;
  localparam logic [3:0]  DD_LAST  = 4'(TIME_W - 1);

  logic [DD_W-1:0]     dd_q;
  logic [DD_W-1:0]     dd_next;
  logic [DIGITS_W-1:0] dd_adj;
  logic [3:0]          dd_cnt;
  logic                dd_busy;

  // One double-dabble step: add 3 to each digit >= 5, then shift left.
  always_comb begin
    dd_adj = dd_q[DD_W-1:TIME_W];
    for (int i = 0; i < 4; i++) begin
      if (dd_adj[4*i +: 4] >= 4'd5) begin
        dd_adj[4*i +: 4] = dd_adj[4*i +: 4] + 4'd3;
      end
    end
    dd_next = {dd_adj, dd_q[TIME_W-1:0]} << 1;
  end

  // A time change (re)loads the converter. bcd holds until the last step lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dd_q      <= '0;
      dd_cnt    <= '0;
      dd_busy   <= 1'b0;
      bcd       <= '0;
      bcd_valid <= 1'b1;
    end else if (time_next != time_out) begin
      dd_q      <= {DIGITS_W'(0), time_next};
      dd_cnt    <= '0;
      dd_busy   <= 1'b1;
      bcd_valid <= 1'b0;
    end else if (dd_busy) begin
      dd_q   <= dd_next;
      dd_cnt <= dd_cnt + 4'd1;
      if (dd_cnt == DD_LAST) begin
        dd_busy   <= 1'b0;
        bcd       <= dd_next[DD_W-1:TIME_W];
        bcd_valid <= 1'b1;
      end
    end
  end
`else
  assign bcd       = '0;
  assign bcd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_meter_controller.sv
// ---------------------------------------------------------------------------
// tb_meter_controller
//   Directed scenarios plus randomized stimulus for meter_controller. A
//   cycle-level reference model, driven from the seconds arithmetic and the
//   event rules, predicts time_out, blank and bcd every cycle.
// ---------------------------------------------------------------------------
module tb_meter_controller;

`ifdef METER_BCD_EN
  // A 10-cycle second is shorter than the 14-cycle conversion, so the BCD
  // build uses a slower tick to let conversions finish between seconds.
  localparam int TB_DIV = 32;
  localparam bit BCD_ON = 1'b1;
`else
  localparam int TB_DIV = 10;
  localparam bit BCD_ON = 1'b0;
`endif
  localparam int HALF  = TB_DIV / 2;
  localparam int MAX_T = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        add_u = 1'b0;
  logic        add_l = 1'b0;
  logic        add_r = 1'b0;
  logic        add_d = 1'b0;
  logic        sw0 = 1'b0;
  logic        sw1 = 1'b0;
  logic [13:0] time_out;
  logic        blank;
  logic [15:0] bcd;
  logic        bcd_valid;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // reference model state
  int          m_e = 0;
  int          m_time = 0;
  int          m_zone = 0;
  int          bcd_left = 0;
  int          nt = 0;
  int          nz = 0;
  logic        m_blank = 1'b0;
  logic        p_sw0 = 1'b0;
  logic        p_sw1 = 1'b0;
  logic        m_bv = BCD_ON;
  logic        m_run;
  logic        m_half;
  logic        m_sec;
  logic [15:0] m_bcd = '0;

  int   k;
  logic saw_blank;

  meter_controller #(
    .TICK_DIV (TB_DIV),
    .MAX_TIME (MAX_T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .add_u     (add_u),
    .add_l     (add_l),
    .add_r     (add_r),
    .add_d     (add_d),
    .sw0       (sw0),
    .sw1       (sw1),
    .time_out  (time_out),
    .blank     (blank),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int zone_of(input int t);
    if (t == 0) return 0;
    if (t < 200) return 1;
    return 2;
  endfunction

  function automatic int sat(input int t);
    return (t > MAX_T) ? MAX_T : t;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  // Model: edge e after release (e = 1 first). The logic runs from e = 2.
  // Half ticks land on e = 1 + n*HALF and seconds on e = 1 + n*TB_DIV.
  task automatic model_step();
    if (!rst_n) begin
      m_e = 0; m_time = 0; m_zone = 0; m_blank = 1'b0;
      p_sw0 = 1'b0; p_sw1 = 1'b0;
      m_bcd = '0; m_bv = BCD_ON; bcd_left = 0;
    end else begin
      m_e++;
      m_run  = (m_e >= 2);
      m_half = m_run && (((m_e - 1) % HALF) == 0);
      m_sec  = m_run && (((m_e - 1) % TB_DIV) == 0);
      if (m_run && add_u)                nt = sat(m_time + 50);
      else if (m_run && add_l)           nt = sat(m_time + 150);
      else if (m_run && add_r)           nt = sat(m_time + 200);
      else if (m_run && add_d)           nt = sat(m_time + 500);
      else if (m_run && sw0 && !p_sw0)   nt = 10;
      else if (m_run && sw1 && !p_sw1)   nt = 205;
      else if (m_sec && m_time > 0)      nt = m_time - 1;
      else                               nt = m_time;
      nz = zone_of(nt);
      if (nz != m_zone)            m_blank = 1'b0;
      else if (nz == 0 && m_half)  m_blank = ~m_blank;
      else if (nz == 1 && m_sec)   m_blank = ~m_blank;
      else if (nz == 2)            m_blank = 1'b0;
      m_zone = nz;
      if (BCD_ON) begin
        if (nt != m_time) begin
          bcd_left = 14;
          m_bv = 1'b0;
        end else if (bcd_left > 0) begin
          bcd_left--;
          if (bcd_left == 0) begin
            m_bcd = to_bcd(nt);
            m_bv = 1'b1;
          end
        end
      end
      m_time = nt;
      p_sw0 = sw0;
      p_sw1 = sw1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("time_out", time_out, m_time);
      check("blank", blank, m_blank);
      check("bcd", bcd, m_bcd);
      check("bcd_valid", bcd_valid, m_bv);
    end
  end

  task automatic pulse(input int which);
    case (which)
      0: add_u = 1'b1;
      1: add_l = 1'b1;
      2: add_r = 1'b1;
      default: add_d = 1'b1;
    endcase
    @(negedge clk);
    add_u = 1'b0; add_l = 1'b0; add_r = 1'b0; add_d = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_time", time_out, 0);
    check("rst_blank", blank, 0);
    check("rst_bcd_valid", bcd_valid, BCD_ON);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_time(input int val, input int budget, input string tag);
    int n = 0;
    while (time_out !== 14'(val) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, time_out, val);
  endtask

  // Align to a blank toggle, then count cycles until the next toggle.
  task automatic measure(input int exp, input string tag);
    logic b;
    int   n;
    b = blank;
    n = 0;
    while (blank === b && n < 4 * TB_DIV) begin
      @(negedge clk);
      n++;
    end
    b = blank;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (blank === b && n < 4 * TB_DIV);
    check(tag, n, exp);
  endtask

  task automatic count_bcd_busy(input logic [15:0] exp_bcd, input string tag);
    int n = 0;
    while (bcd_valid === 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_cycles"}, n, 14);
    check({tag, "_value"}, bcd, exp_bcd);
  endtask

  initial begin
    // reset values and synchronised release
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset_time", time_out, 0);
    check("reset_blank", blank, 0);
    check("reset_bcd", bcd, 0);
    check("reset_bcd_valid", bcd_valid, BCD_ON);
    rst_n = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (blank !== 1'b1 && k < 4 * HALF);
    check("first_half_tick", k, HALF + 1);

    // saturation with add_d pulses, solid display throughout
    saw_blank = 1'b0;
    repeat (20) begin
      pulse(3);
      saw_blank = saw_blank | blank;
      @(negedge clk);
      saw_blank = saw_blank | blank;
    end
    check("sat_time", time_out, MAX_T);
    check("sat_blank_seen", saw_blank, 0);

    // sw1 preset, LOW entry and 0.5 Hz flash
    sw1 = 1'b1;
    @(negedge clk);
    check("sw1_preset", time_out, 205);
    wait_time(199, 7 * TB_DIV + 4, "low_entry");
    check("low_entry_blank", blank, 0);
    measure(TB_DIV, "low_flash");
    sw1 = 1'b0;

    // sw0 preset, ZERO entry, 1 Hz flash, hold at zero
    sw0 = 1'b1;
    @(negedge clk);
    check("sw0_preset", time_out, 10);
    wait_time(0, 11 * TB_DIV + 4, "zero_entry");
    check("zero_entry_blank", blank, 0);
    measure(HALF, "zero_flash");
    repeat (3 * TB_DIV) @(negedge clk);
    check("zero_hold", time_out, 0);
    sw0 = 1'b0;

    // add_u and add_d together at 100 on a second boundary
    pulse(1);
    check("add_l", time_out, 150);
    wait_time(100, 52 * TB_DIV, "count_to_100");
    k = 0;
    while ((m_e % TB_DIV) != 0 && k < 2 * TB_DIV) begin
      @(negedge clk);
      k++;
    end
    check("pre_tie", time_out, 100);
    add_u = 1'b1;
    add_d = 1'b1;
    @(negedge clk);
    add_u = 1'b0;
    add_d = 1'b0;
    check("tie_break", time_out, 150);

    // saturating add from just below the limit
    repeat (20) begin
      pulse(3);
    end
    wait_time(9990, 11 * TB_DIV, "count_to_9990");
    pulse(0);
    check("sat_add_u", time_out, MAX_T);

`ifdef METER_BCD_EN
    // conversion of 1234 and a restart in mid-conversion
    do_reset();
    repeat (2) @(negedge clk);
    pulse(3);
    pulse(3);
    pulse(2);
    pulse(0);
    wait_time(1234, 20 * TB_DIV, "bcd_reach_1234");
    count_bcd_busy(16'h1234, "bcd_1234");
    wait_time(1233, 2 * TB_DIV, "bcd_reach_1233");
    repeat (4) @(negedge clk);
    check("bcd_hold_during_conv", bcd, 16'h1234);
    check("bcd_valid_during_conv", bcd_valid, 0);
    pulse(0);
    check("bcd_restart_time", time_out, 1283);
    count_bcd_busy(16'h1283, "bcd_restart");
`endif

    // reset mid-countdown with sw0 held high
    sw0 = 1'b1;
    @(negedge clk);
    check("sw0_preset2", time_out, 10);
    repeat (3 * TB_DIV) @(negedge clk);
    do_reset();
    repeat (4 * TB_DIV) @(negedge clk);
    check("no_preset_after_release", time_out, 0);
    sw0 = 1'b0;
    repeat (2) @(negedge clk);
    sw0 = 1'b1;
    @(negedge clk);
    check("preset_after_rerise", time_out, 10);

    // randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      add_u = ($urandom_range(0, 149) == 0);
      add_l = ($urandom_range(0, 199) == 0);
      add_r = ($urandom_range(0, 199) == 0);
      add_d = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) sw0 = ~sw0;
      if ($urandom_range(0, 59) == 0) sw1 = ~sw1;
      if ($urandom_range(0, 1499) == 0) begin
        add_u = 1'b0; add_l = 1'b0; add_r = 1'b0; add_d = 1'b0;
        do_reset();
      end else begin
        @(negedge clk);
      end
    end
    add_u = 1'b0; add_l = 1'b0; add_r = 1'b0; add_d = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
